// File: rtl/ita_weight_buffer.sv
// Double-banked weight buffer: assembles N_SLICE slices per bank and serves
// whole-bank words to the PE array, releasing each bank after S reads.
module ita_weight_buffer #(
    parameter int SLICE_W = 128,
    parameter int N_SLICE = 4,
    parameter int S       = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       write_en_i,
    input  logic                       write_addr_i,
    input  logic [N_SLICE*SLICE_W-1:0] write_data_i,
    input  logic [N_SLICE-1:0]         write_select_i,
    input  logic                       read_en_i,
    input  logic                       read_addr_i,
    output logic [N_SLICE*SLICE_W-1:0] weight_o,
    output logic                       weight_valid_o,
    output logic [1:0]                 bank_full_o,
    output logic                       err_overwrite_o,
    output logic                       err_partial_read_o,
    output logic                       err_select_o,
    input  logic                       clear_err_i
);

    localparam int W  = N_SLICE * SLICE_W;
    localparam int CW = $clog2(S + 1);

    logic [SLICE_W-1:0] mem [2][N_SLICE];
    logic [N_SLICE-1:0] fill [2];
    logic [CW-1:0]      cnt [2];

    logic [N_SLICE-1:0] fill_base [2];
    logic [N_SLICE-1:0] fill_next [2];
    logic [1:0]         release_bank;
    logic [W-1:0]       rd_word;
    logic               set_overwrite;
    logic               set_partial;
    logic               set_select;

    // Release clears the fill mask before a same-cycle write sets its bit,
    // so a write landing on the final read is not an overwrite.
    always_comb begin
        release_bank = '0;
        rd_word      = '0;
        for (int b = 0; b < 2; b++) begin
            release_bank[b] = read_en_i && (int'(read_addr_i) == b)
                              && (cnt[b] == CW'(S - 1));
            fill_base[b] = release_bank[b] ? '0 : fill[b];
            fill_next[b] = fill_base[b];
            if (write_en_i && (int'(write_addr_i) == b)) begin
                fill_next[b] = fill_base[b] | write_select_i;
            end
            bank_full_o[b] = &fill[b];
        end
        for (int k = 0; k < N_SLICE; k++) begin
            rd_word[k*SLICE_W +: SLICE_W] = mem[read_addr_i][k];
        end
        set_overwrite = write_en_i
                        && (|(write_select_i & fill_base[write_addr_i]));
        set_select    = write_en_i
                        && ((write_select_i == '0)
                        || (|(write_select_i & (write_select_i - N_SLICE'(1)))));
        set_partial   = read_en_i && !(&fill[read_addr_i]);
    end

    // Storage carries no reset; fill masks gate what counts as valid data.
    always_ff @(posedge clk_i) begin
        if (write_en_i) begin
            for (int k = 0; k < N_SLICE; k++) begin
                if (write_select_i[k]) begin
                    mem[write_addr_i][k] <= write_data_i[k*SLICE_W +: SLICE_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            weight_o           <= '0;
            weight_valid_o     <= 1'b0;
            err_overwrite_o    <= 1'b0;
            err_partial_read_o <= 1'b0;
            err_select_o       <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                fill[b] <= '0;
                cnt[b]  <= '0;
            end
        end else begin
            weight_valid_o <= read_en_i;
            if (read_en_i) begin
                weight_o <= rd_word;
            end
            for (int b = 0; b < 2; b++) begin
                fill[b] <= fill_next[b];
                if (read_en_i && (int'(read_addr_i) == b)) begin
                    cnt[b] <= release_bank[b] ? '0 : cnt[b] + CW'(1);
                end
            end
            if (clear_err_i) begin
                err_overwrite_o    <= 1'b0;
                err_partial_read_o <= 1'b0;
                err_select_o       <= 1'b0;
            end else begin
                err_overwrite_o    <= err_overwrite_o | set_overwrite;
                err_partial_read_o <= err_partial_read_o | set_partial;
                err_select_o       <= err_select_o | set_select;
            end
        end
    end

endmodule

// File: tb/tb_ita_weight_buffer.sv
// Scenario bench for ita_weight_buffer (SLICE_W=8, N_SLICE=4, S=4);
// read data is checked through a scoreboard queue.
module tb_ita_weight_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_en = 1'b0;
    logic        write_addr = 1'b0;
    logic [31:0] write_data = '0;
    logic [3:0]  write_select = '0;
    logic        read_en = 1'b0;
    logic        read_addr = 1'b0;
    logic        clear_err = 1'b0;
    logic [31:0] weight;
    logic        weight_valid;
    logic [1:0]  bank_full;
    logic        err_ov;
    logic        err_pr;
    logic        err_sel;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    logic        rd_sampled = 1'b0;

    ita_weight_buffer #(.SLICE_W(8), .N_SLICE(4), .S(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .write_en_i(write_en),
        .write_addr_i(write_addr),
        .write_data_i(write_data),
        .write_select_i(write_select),
        .read_en_i(read_en),
        .read_addr_i(read_addr),
        .weight_o(weight),
        .weight_valid_o(weight_valid),
        .bank_full_o(bank_full),
        .err_overwrite_o(err_ov),
        .err_partial_read_o(err_pr),
        .err_select_o(err_sel),
        .clear_err_i(clear_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_sampled <= rst ? 1'b0 : read_en;

    // Scoreboard: a read issued last cycle must show valid and the queued word.
    always @(negedge clk) begin
        checks++;
        if (weight_valid !== rd_sampled) begin
            $display("FAIL valid: got %b want %b t=%0t",
                     weight_valid, rd_sampled, $time);
            errors++;
        end
        if (rd_sampled === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_underflow: read data %h with no expectation", weight);
                errors++;
            end else begin
                logic [31:0] exp_w;
                exp_w = sb.pop_front();
                if (weight !== exp_w) begin
                    $display("FAIL read_data: got %h want %h t=%0t",
                             weight, exp_w, $time);
                    errors++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en     = 1'b0;
        write_select = '0;
        read_en      = 1'b0;
        clear_err    = 1'b0;
    endtask

    task automatic set_wr(input logic bank, input logic [3:0] sel,
                          input logic [7:0] b);
        write_en     = 1'b1;
        write_addr   = bank;
        write_select = sel;
        write_data   = {4{b}};
    endtask

    task automatic set_rd(input logic bank, input logic [31:0] exp_w);
        read_en   = 1'b1;
        read_addr = bank;
        sb.push_back(exp_w);
    endtask

    task automatic fill_bank(input logic bank, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            idle();
            set_wr(bank, 4'b0001 << k, w[k*8 +: 8]);
            step();
        end
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        checks++;
        if (weight !== 32'h0) begin
            $display("FAIL reset_weight: got %h want 0", weight); errors++;
        end
        checks++;
        if (bank_full !== 2'b00) begin
            $display("FAIL reset_full: got %b want 00", bank_full); errors++;
        end
        checks++;
        if ({err_ov, err_pr, err_sel} !== 3'b000) begin
            $display("FAIL reset_err: got %b want 000", {err_ov, err_pr, err_sel});
            errors++;
        end
    endtask

    task automatic test_fill_read();
        logic [3:0] exp_full;
        exp_full = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            idle();
            set_wr(1'b0, 4'b0001 << k, 8'h11 * 8'(k + 1));
            step();
            checks++;
            if (bank_full[0] !== exp_full[k]) begin
                $display("FAIL fill_full_w%0d: got %b want %b",
                         k, bank_full[0], exp_full[k]);
                errors++;
            end
        end
        for (int r = 0; r < 4; r++) begin
            idle();
            set_rd(1'b0, 32'h44332211);
            step();
            checks++;
            if (bank_full[0] !== (r < 3)) begin
                $display("FAIL fill_full_r%0d: got %b want %b",
                         r, bank_full[0], r < 3);
                errors++;
            end
        end
        idle();
        step();
        checks++;
        if (weight !== 32'h44332211) begin
            $display("FAIL hold_weight: got %h want 44332211", weight); errors++;
        end
        checks++;
        if ({err_ov, err_pr, err_sel} !== 3'b000) begin
            $display("FAIL fill_err: got %b want 000", {err_ov, err_pr, err_sel});
            errors++;
        end
    endtask

    task automatic test_ping_pong();
        fill_bank(1'b0, 32'h44332211);
        for (int k = 0; k < 4; k++) begin
            idle();
            set_wr(1'b1, 4'b0001 << k, 8'hA1 + 8'(k));
            set_rd(1'b0, 32'h44332211);
            step();
        end
        idle();
        checks++;
        if (bank_full !== 2'b10) begin
            $display("FAIL pp_full: got %b want 10", bank_full); errors++;
        end
        for (int r = 0; r < 4; r++) begin
            idle();
            set_rd(1'b1, 32'hA4A3A2A1);
            step();
        end
        idle();
        checks++;
        if (bank_full !== 2'b00) begin
            $display("FAIL pp_release: got %b want 00", bank_full); errors++;
        end
        checks++;
        if ({err_ov, err_pr, err_sel} !== 3'b000) begin
            $display("FAIL pp_err: got %b want 000", {err_ov, err_pr, err_sel});
            errors++;
        end
    endtask

    task automatic test_read_before_write();
        fill_bank(1'b0, 32'h44332211);
        set_wr(1'b0, 4'b0100, 8'h99);
        set_rd(1'b0, 32'h44332211);
        step();
        idle();
        checks++;
        if (err_ov !== 1'b1) begin
            $display("FAIL rbw_overwrite: got %b want 1", err_ov); errors++;
        end
        for (int r = 0; r < 3; r++) begin
            idle();
            set_rd(1'b0, 32'h44992211);
            step();
        end
        idle();
        clear_err = 1'b1;
        step();
        idle();
        checks++;
        if (err_ov !== 1'b0) begin
            $display("FAIL rbw_clear: got %b want 0", err_ov); errors++;
        end
    endtask

    task automatic test_errors();
        set_rd(1'b1, 32'hA4A3A2A1);
        step();
        idle();
        checks++;
        if (err_pr !== 1'b1) begin
            $display("FAIL partial_read: got %b want 1", err_pr); errors++;
        end
        set_wr(1'b1, 4'b0110, 8'hB6);
        step();
        idle();
        checks++;
        if (err_sel !== 1'b1) begin
            $display("FAIL select_multi: got %b want 1", err_sel); errors++;
        end
        set_wr(1'b1, 4'b0001, 8'hB0);
        step();
        set_wr(1'b1, 4'b1000, 8'hB3);
        step();
        idle();
        checks++;
        if (bank_full[1] !== 1'b1 || err_ov !== 1'b0) begin
            $display("FAIL err_refill: full %b ov %b want 1 0", bank_full[1], err_ov);
            errors++;
        end
        for (int r = 0; r < 3; r++) begin
            idle();
            set_rd(1'b1, 32'hB3B6B6B0);
            step();
            checks++;
            if (bank_full[1] !== (r < 2)) begin
                $display("FAIL cnt_advance_r%0d: got %b want %b",
                         r, bank_full[1], r < 2);
                errors++;
            end
        end
        idle();
        checks++;
        if (err_pr !== 1'b1 || err_sel !== 1'b1) begin
            $display("FAIL sticky: pr %b sel %b want 1 1", err_pr, err_sel);
            errors++;
        end
        clear_err = 1'b1;
        step();
        idle();
        checks++;
        if ({err_ov, err_pr, err_sel} !== 3'b000) begin
            $display("FAIL clear_err: got %b want 000", {err_ov, err_pr, err_sel});
            errors++;
        end
        set_wr(1'b1, 4'b0000, 8'h00);
        clear_err = 1'b1;
        step();
        idle();
        checks++;
        if (err_sel !== 1'b0) begin
            $display("FAIL clear_priority: got %b want 0", err_sel); errors++;
        end
    endtask

    task automatic test_release_collision();
        fill_bank(1'b0, 32'h44332211);
        for (int r = 0; r < 3; r++) begin
            idle();
            set_rd(1'b0, 32'h44332211);
            step();
        end
        idle();
        set_rd(1'b0, 32'h44332211);
        set_wr(1'b0, 4'b0001, 8'h55);
        step();
        idle();
        checks++;
        if (bank_full[0] !== 1'b0 || err_ov !== 1'b0) begin
            $display("FAIL collide: full %b ov %b want 0 0", bank_full[0], err_ov);
            errors++;
        end
        for (int k = 1; k < 4; k++) begin
            idle();
            set_wr(1'b0, 4'b0001 << k, 8'h11 * 8'(k + 1));
            step();
        end
        idle();
        checks++;
        if (bank_full[0] !== 1'b1 || err_ov !== 1'b0) begin
            $display("FAIL collide_fill: full %b ov %b want 1 0", bank_full[0], err_ov);
            errors++;
        end
        set_rd(1'b0, 32'h44332255);
        step();
        idle();
    endtask

    task automatic test_mid_reset();
        set_rd(1'b0, 32'h44332255);
        step();
        read_en   = 1'b1;
        read_addr = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        idle();
        checks++;
        if (bank_full !== 2'b00 || weight_valid !== 1'b0 || weight !== 32'h0) begin
            $display("FAIL mid_reset: full %b valid %b w %h want 00 0 0",
                     bank_full, weight_valid, weight);
            errors++;
        end
        fill_bank(1'b0, 32'hC4C3C2C1);
        for (int r = 0; r < 4; r++) begin
            idle();
            set_rd(1'b0, 32'hC4C3C2C1);
            step();
            checks++;
            if (bank_full[0] !== (r < 3)) begin
                $display("FAIL rst_release_r%0d: got %b want %b",
                         r, bank_full[0], r < 3);
                errors++;
            end
        end
        idle();
        checks++;
        if ({err_ov, err_pr, err_sel} !== 3'b000) begin
            $display("FAIL rst_err: got %b want 000", {err_ov, err_pr, err_sel});
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_ping_pong();
        test_read_before_write();
        test_errors();
        test_release_collision();
        test_mid_reset();
        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL sb_leftover: %0d reads never returned", sb.size());
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ita_weight_buffer.md
Name: ita_weight_buffer

Overview:
Double-banked weight storage directly downstream of the weight controller. It takes the controller's write side (bank address, per-slice select, slice data) and read side (read enable, bank address). It assembles N_SLICE slices per bank and presents the full bank as one registered weight word to the PE array, one cycle after each read. It also tracks per-bank fill and consumption, and flags protocol violations as sticky errors.

Parameters:
SLICE_W, 128, width in bits of one input weight slice
N_SLICE, 4, slices per bank; equals the controller's write-enable count; power of two, >=2
S, 64, reads per bank before the bank is released; >=1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
write_en_i  in  1  slice write strobe
write_addr_i  in  1  bank being written
write_data_i  in  N_SLICE*SLICE_W  slice k at bits [k*SLICE_W +: SLICE_W]
write_select_i  in  N_SLICE  one-hot slice select, qualified by write_en_i
read_en_i  in  1  read strobe
read_addr_i  in  1  bank being read
weight_o  out  N_SLICE*SLICE_W  registered bank contents
weight_valid_o  out  1  weight_o updated this cycle
bank_full_o  out  2  bank b holds all N_SLICE slices
err_overwrite_o  out  1  sticky: slice rewritten before release
err_partial_read_o  out  1  sticky: read of a non-full bank
err_select_o  out  1  sticky: write_select_i not one-hot while write_en_i=1
clear_err_i  in  1  clears all sticky errors

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Storage: mem[2][N_SLICE] of SLICE_W. Storage is not reset.
- Reset values on the cycle after rst_i=1:
  - weight_o=0, weight_valid_o=0, bank_full_o=0, all errors=0
  - fill masks=0, read counters=0
- Reset mid-fill or mid-read discards all progress. Stale storage is never presented until it has been refilled.
- Write (write_en_i=1): for each k with write_select_i[k]=1:
  - mem[write_addr_i][k] <= slice k
  - fill[write_addr_i][k] <= 1
  - If that fill bit was already 1, set err_overwrite_o; the write still occurs.
  - If write_select_i is zero or multi-hot, set err_select_o. All selected slices are written.
- Fill tracking: bank_full_o[b] = &fill[b], driven from registers (no combinational path from write inputs).
- Read (read_en_i=1):
  - Next cycle: weight_o = concatenation of mem[read_addr_i][N_SLICE-1..0], weight_valid_o=1. Latency is exactly 1.
  - Without read_en_i: weight_valid_o=0 and weight_o holds its last value.
  - Reading a bank with bank_full_o=0 sets err_partial_read_o. Data is still returned and the counter still advances.
- Consumption: cnt[read_addr_i] increments on each read. When it reaches S:
  - cnt -> 0
  - fill[read_addr_i] -> 0, so bank_full_o drops the next cycle
- Simultaneous events:
  - Write and read on the same bank and slice in one cycle: the read returns the OLD data (read-before-write).
  - Write to bank A and read of bank B: both proceed independently.
  - Final (S-th) read of bank b coincident with a write to bank b slice k: the release clears fill[b] except bit k, which is set by the write. No overwrite error is raised, because release takes priority before the set.
- Error handling:
  - Error flags are sticky until clear_err_i=1 or reset.
  - clear_err_i takes priority over a same-cycle error set: that error is lost.
- Counter width: $clog2(S+1). The counter never exceeds S-1 at a register boundary.

Test Plan:
Bench configuration for all scenarios: SLICE_W=8, N_SLICE=4, S=4.
- Fill bank 0 with slices 0x11,0x22,0x33,0x44 (select 0001..1000), then read bank0 4 times -> weight_o=0x44332211 with valid on each following cycle; bank_full_o[0] 0->1 after the 4th write, 1->0 the cycle after the 4th read; no errors.
- Ping-pong: fill bank1 (0xA1..0xA4) while reading bank0 in the same cycles -> bank0 reads return 0x44332211 unaffected; bank1 full after 4 writes; then 4 reads of bank1 return 0xA4A3A2A1.
- Same-cycle read of bank0 and write of bank0 slice2 = 0x99 with bank0 full -> read data 0x44332211 (old); err_overwrite_o=1 the next cycle; a subsequent read returns 0x44992211.
- Read bank1 while empty -> err_partial_read_o=1; bank1 counter advances. Then write_en_i with select 0110 -> err_select_o=1; clear_err_i=1 -> all errors 0 the next cycle.
- 4th read of full bank0 coincident with a write of bank0 slice0 = 0x55 -> next cycle fill[0]=0001, bank_full_o[0]=0, err_overwrite_o=0.
- Assert rst_i after 2 of 4 reads of a full bank -> next cycle bank_full_o=0, weight_valid_o=0, weight_o=0. Refill with new data, then 4 reads -> new data returned, and release occurs after exactly 4 reads.
